// File: rtl/ballot_booth_controller.sv
// Purpose : booth front-end; turns officer AUTH and three raw candidate buttons into
//           the ENABLE / VOTE_IN strobe pair, one accepted vote per authorisation.
// Latency : raw button high to ENABLE/VOTE_IN = 2 sync + STABLE_CYCLES debounce + 1 FSM edge.
// Backpres: none; a held button parks the FSM in RELEASE until all buttons are let go.
// Ports   : CLK, RESET (async active-low); AUTH, BTN_A/B/C raw inputs;
//           ENABLE, VOTE_IN[1:0], READY, MULTI_ERR, TIMEOUT_ERR pulses,
//           voters_served[7:0] saturating count, state[2:0] debug view.
module ballot_booth_controller #(
  parameter int STABLE_CYCLES  = 3,
  parameter int TIMEOUT_CYCLES = 50
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       AUTH,
  input  logic       BTN_A,
  input  logic       BTN_B,
  input  logic       BTN_C,
  output logic       ENABLE,
  output logic [1:0] VOTE_IN,
  output logic       READY,
  output logic       MULTI_ERR,
  output logic       TIMEOUT_ERR,
  output logic [7:0] voters_served,
  output logic [2:0] state
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE    = 3'b000,
    ARMED   = 3'b001,
    CAST    = 3'b010,
    HOLD    = 3'b011,
    RELEASE = 3'b100,
    TOUT    = 3'b101
  } state_t;

  state_t          cur_state;
  logic [3:0]      sync1;      // {AUTH, C, B, A}
  logic [3:0]      sync2;
  logic            auth_d;
  logic [TW-1:0]   timer;
  logic [CW-1:0]   cnt [3];
  logic [2:0]      db;         // {C, B, A} debounced
  logic            auth_rise;
  logic            multi;
  logic            one;
  logic [1:0]      code;

  assign state = cur_state;

  // Two-flop synchronisers plus the delayed AUTH copy used for edge detection.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sync1  <= '0;
      sync2  <= '0;
      auth_d <= 1'b0;
    end else begin
      sync1  <= {AUTH, BTN_C, BTN_B, BTN_A};
      sync2  <= sync1;
      auth_d <= sync2[3];
    end
  end

  assign auth_rise = sync2[3] & ~auth_d;

  // Per-button run-length counters; any low sample restarts the count, so pulses
  // shorter than STABLE_CYCLES synchronised cycles never reach the FSM.
  for (genvar i = 0; i < 3; i++) begin : g_deb
    always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
        cnt[i] <= '0;
      end else if (!sync2[i]) begin
        cnt[i] <= '0;
      end else if (cnt[i] != CW'(STABLE_CYCLES)) begin
        cnt[i] <= cnt[i] + 1'b1;
      end
    end
    assign db[i] = (cnt[i] == CW'(STABLE_CYCLES));
  end

  assign multi = (db[0] & db[1]) | (db[0] & db[2]) | (db[1] & db[2]);
  assign one   = (|db) & ~multi;
  assign code  = db[0] ? 2'b01 : (db[1] ? 2'b10 : 2'b11);

  // Outputs are assigned alongside the state they belong to, so each output is
  // valid in the same cycle its state becomes visible.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cur_state     <= IDLE;
      timer         <= '0;
      ENABLE        <= 1'b0;
      VOTE_IN       <= 2'b00;
      READY         <= 1'b0;
      MULTI_ERR     <= 1'b0;
      TIMEOUT_ERR   <= 1'b0;
      voters_served <= 8'd0;
    end else begin
      ENABLE      <= 1'b0;
      VOTE_IN     <= 2'b00;
      READY       <= 1'b0;
      MULTI_ERR   <= 1'b0;
      TIMEOUT_ERR <= 1'b0;
      case (cur_state)
        IDLE: begin
          if (auth_rise && db == 3'b000) begin
            cur_state <= ARMED;
            timer     <= '0;
            READY     <= 1'b1;
          end
        end
        ARMED: begin
          // A clean press wins over expiry on the same cycle.
          if (one) begin
            cur_state <= CAST;
            ENABLE    <= 1'b1;
            VOTE_IN   <= code;
            if (voters_served != 8'hFF) voters_served <= voters_served + 8'd1;
          end else if (multi) begin
            cur_state <= RELEASE;
            MULTI_ERR <= 1'b1;
          end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
            cur_state   <= TOUT;
            TIMEOUT_ERR <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
            READY <= 1'b1;
          end
        end
        CAST: begin
          cur_state <= HOLD;
          ENABLE    <= 1'b1;
        end
        HOLD: begin
          cur_state <= RELEASE;
        end
        RELEASE: begin
          // Wait for every button to be released so a held press cannot vote twice.
          if (db == 3'b000) cur_state <= IDLE;
        end
        TOUT: begin
          cur_state <= IDLE;
        end
        default: begin
          cur_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ballot_booth_controller.sv
// Purpose : scoreboard bench for ballot_booth_controller; directed booth sessions.
// Latency : expected strobes carry their hand-computed cycle where it matters.
// Backpres: n/a.
module tb_ballot_booth_controller;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       AUTH, BTN_A, BTN_B, BTN_C;
  logic       ENABLE;
  logic [1:0] VOTE_IN;
  logic       READY, MULTI_ERR, TIMEOUT_ERR;
  logic [7:0] voters_served;
  logic [2:0] state;

  ballot_booth_controller dut (
    .CLK(CLK), .RESET(RESET), .AUTH(AUTH),
    .BTN_A(BTN_A), .BTN_B(BTN_B), .BTN_C(BTN_C),
    .ENABLE(ENABLE), .VOTE_IN(VOTE_IN), .READY(READY),
    .MULTI_ERR(MULTI_ERR), .TIMEOUT_ERR(TIMEOUT_ERR),
    .voters_served(voters_served), .state(state)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int kind;   // 1 cast, 2 multi error, 3 timeout error
    int code;
    int vs;
    int cyc;    // -1: cycle not checked
  } ev_t;

  ev_t exp_q[$];
  int  compared   = 0;
  int  mismatched = 0;
  int  cyc        = 0;
  bit  trace_en   = 1'b0;
  int  last_st    = 0;
  int  trace_q[$];
  int  en_cnt     = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic handle(input int kind, input int code, input int vs);
    ev_t e;
    if (exp_q.size() == 0) begin
      compared++;
      mismatched++;
      $display("FAIL unexpected_event: kind %0d code %0d served %0d, none expected (cycle %0d)",
               kind, code, vs, cyc);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      check("event_code", code, e.code);
      check("event_served", vs, e.vs);
      if (e.cyc >= 0) check("event_cycle", cyc, e.cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT strobes a vote or an error.
  always @(negedge CLK) begin
    if (ENABLE) check("enable_only_cast_hold", int'(state == 3'b010 || state == 3'b011), 1);
    if (VOTE_IN != 2'b00) check("vote_only_in_cast", int'(state), 2);
    if (ENABLE && VOTE_IN != 2'b00) handle(1, int'(VOTE_IN), int'(voters_served));
    if (MULTI_ERR) handle(2, 0, int'(voters_served));
    if (TIMEOUT_ERR) handle(3, 0, int'(voters_served));
  end

  always @(negedge CLK) begin
    if (trace_en) begin
      if (int'(state) != last_st) begin
        trace_q.push_back(int'(state));
        last_st = int'(state);
      end
      if (ENABLE) en_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic auth_pulse();
    AUTH = 1'b1;
    tick(1);
    AUTH = 1'b0;
  endtask

  task automatic set_btn(input int code, input logic v);
    case (code)
      1: BTN_A = v;
      2: BTN_B = v;
      default: BTN_C = v;
    endcase
  endtask

  function automatic ev_t mk(input int kind, input int code, input int vs, input int c);
    ev_t e;
    e.kind = kind; e.code = code; e.vs = vs; e.cyc = c;
    return e;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int q, p, c;
    int exp_trace[5];
    RESET = 1'b0; AUTH = 1'b0; BTN_A = 1'b0; BTN_B = 1'b0; BTN_C = 1'b0;
    tick(3);
    check("rst_enable", int'(ENABLE), 0);
    check("rst_vote_in", int'(VOTE_IN), 0);
    check("rst_ready", int'(READY), 0);
    check("rst_multi", int'(MULTI_ERR), 0);
    check("rst_timeout", int'(TIMEOUT_ERR), 0);
    check("rst_served", int'(voters_served), 0);
    check("rst_state", int'(state), 0);
    RESET = 1'b1;
    tick(2);

    // 1: press without authorisation.
    BTN_A = 1'b1;
    tick(10);
    check("noauth_state", int'(state), 0);
    check("noauth_served", int'(voters_served), 0);
    BTN_A = 1'b0;
    tick(6);

    // 2: clean vote for B, state walk and strobe width.
    trace_en = 1'b1; last_st = 0; en_cnt = 0;
    auth_pulse();
    tick(3);
    p = cyc;
    exp_q.push_back(mk(1, 2, 1, p + 6));
    BTN_B = 1'b1;
    tick(8);
    BTN_B = 1'b0;
    tick(10);
    trace_en = 1'b0;
    exp_trace = '{1, 2, 3, 4, 0};
    check("walk_len", trace_q.size(), 5);
    for (int i = 0; i < 5; i++)
      check("walk_state", (i < trace_q.size()) ? trace_q[i] : -1, exp_trace[i]);
    check("enable_cycles", en_cnt, 2);
    check("served_after_b", int'(voters_served), 1);

    // 3: A and C together.
    auth_pulse();
    tick(3);
    exp_q.push_back(mk(2, 0, 1, -1));
    BTN_A = 1'b1; BTN_C = 1'b1;
    tick(8);
    BTN_A = 1'b0; BTN_C = 1'b0;
    tick(8);
    check("multi_idle", int'(state), 0);
    check("multi_served", int'(voters_served), 1);

    // 4: idle booth times out, later press is ignored.
    q = cyc;
    auth_pulse();
    exp_q.push_back(mk(3, 0, 1, q + 53));
    tick(60);
    BTN_C = 1'b1;
    tick(10);
    BTN_C = 1'b0;
    tick(6);
    check("tout_served", int'(voters_served), 1);
    check("tout_idle", int'(state), 0);

    // 5: AUTH with held button ignored; glitch rejected; full press counts.
    BTN_A = 1'b1;
    tick(6);
    auth_pulse();
    tick(6);
    check("held_auth_ignored", int'(state), 0);
    BTN_A = 1'b0;
    tick(6);
    auth_pulse();
    tick(3);
    BTN_A = 1'b1;
    tick(2);
    BTN_A = 1'b0;
    tick(8);
    check("glitch_still_armed", int'(state), 1);
    exp_q.push_back(mk(1, 1, 2, -1));
    BTN_A = 1'b1;
    tick(8);
    BTN_A = 1'b0;
    tick(8);
    check("full_press_served", int'(voters_served), 2);
    check("full_press_idle", int'(state), 0);

    // 6: async reset in CAST, before the monitor can sample the strobe.
    auth_pulse();
    tick(3);
    BTN_A = 1'b1;
    tick(6);
    check("pre_reset_in_cast", int'(state), 2);
    #2 RESET = 1'b0;
    #1;
    check("abort_enable", int'(ENABLE), 0);
    check("abort_vote_in", int'(VOTE_IN), 0);
    check("abort_served", int'(voters_served), 0);
    check("abort_state", int'(state), 0);
    tick(1);
    RESET = 1'b1;
    BTN_A = 1'b0;
    tick(8);
    check("post_reset_state", int'(state), 0);
    check("post_reset_served", int'(voters_served), 0);

    // Saturation: 256 accepted votes cycling through A, B, C.
    for (int k = 1; k <= 256; k++) begin
      c = ((k - 1) % 3) + 1;
      auth_pulse();
      tick(3);
      p = cyc;
      exp_q.push_back(mk(1, c, (k > 255) ? 255 : k, p + 6));
      set_btn(c, 1'b1);
      tick(7);
      set_btn(c, 1'b0);
      tick(6);
    end
    check("saturated_served", int'(voters_served), 255);

    tick(4);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
